// File: rtl/data_ram_resp.sv
// Data-memory responder: accepts one byte-lane load/store at a time and acks LATENCY cycles later.
// Define DRAM_ALIGN_CHK_EN to add resp_err, flagging illegal lane/alignment combinations.
module data_ram_resp #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_ce,
   input  logic        req_we,
   input  logic [3:0]  req_sel,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_ack,
   output logic [31:0] resp_rdata,
`ifdef DRAM_ALIGN_CHK_EN
   output logic        resp_err,
`endif
   output logic        stallreq
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic                we_reg;
   logic                err_reg;
   logic [ADDR_W-1:0]   idx_reg;

   logic                accept;
   logic                req_err;
   logic [ADDR_W-1:0]   req_idx;
   logic [ADDR_W-1:0]   rd_idx;
   logic                rd_zero;
   logic [31:0]         rd_word;
   logic                unused_addr;

   assign req_idx = req_addr[ADDR_W+1:2];
   assign accept  = (state_reg == IDLE) && req_ce;

`ifdef DRAM_ALIGN_CHK_EN
   always_comb begin
      case (req_sel)
         4'b1111:                            req_err = (req_addr[1:0] != 2'b00);
         4'b0011, 4'b1100:                   req_err = req_addr[0];
         4'b0001, 4'b0010, 4'b0100, 4'b1000: req_err = 1'b0;
         default:                            req_err = 1'b1;
      endcase
   end
   assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};
`else
   assign req_err     = 1'b0;
   assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // cnt holds the number of edges still to pass before entering RESP
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (req_ce) begin
               if (LATENCY == 1) begin
                  state_next = RESP;
                  cnt_next   = '0;
               end else begin
                  state_next = WAIT;
                  cnt_next   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_reg <= 4'd1) begin
               state_next = RESP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_reg  <= 1'b0;
         err_reg <= 1'b0;
         idx_reg <= '0;
      end else if (accept) begin
         we_reg  <= req_we;
         err_reg <= req_err;
         idx_reg <= req_idx;
      end
   end

   // One byte-wide array per lane so each lane write-enable maps onto a RAM column
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         always_ff @(posedge clk) begin
            if (accept && req_we && !req_err && req_sel[gi])
               lane_mem[req_idx] <= req_wdata[8*gi +: 8];
         end

         assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
      end
   endgenerate

   // With LATENCY=1 RESP is entered straight from IDLE, so read from the live request
   assign rd_idx  = (state_reg == IDLE) ? req_idx : idx_reg;
   assign rd_zero = (state_reg == IDLE) ? (req_we | req_err) : (we_reg | err_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         resp_rdata <= '0;
      else if (state_next == RESP)
         resp_rdata <= rd_zero ? 32'h0 : rd_word;
   end

   assign req_ready = (state_reg == IDLE);
   assign resp_ack  = (state_reg == RESP);
   assign stallreq  = req_ce & ~resp_ack;
`ifdef DRAM_ALIGN_CHK_EN
   assign resp_err  = resp_ack & err_reg;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed plus randomized bench for data_ram_resp against an array-based memory model.
module tb_data_ram_resp;

   localparam int ADDR_W  = 10;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_ce = 1'b0;
   logic        req_we = 1'b0;
   logic [3:0]  req_sel = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        resp_ack;
   logic [31:0] resp_rdata;
   logic        stallreq;
`ifdef DRAM_ALIGN_CHK_EN
   logic        resp_err;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [int];
   logic [31:0] last_rdata = '0;

   always #5 clk = ~clk;

   data_ram_resp #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_ce    (req_ce),
      .req_we    (req_we),
      .req_sel   (req_sel),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .resp_ack  (resp_ack),
      .resp_rdata(resp_rdata),
`ifdef DRAM_ALIGN_CHK_EN
      .resp_err  (resp_err),
`endif
      .stallreq  (stallreq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [3:0] sel, input logic [1:0] lo);
`ifdef DRAM_ALIGN_CHK_EN
      if (sel == 4'b1111) return lo == 2'b00;
      if (sel == 4'b0011 || sel == 4'b1100) return lo[0] == 1'b0;
      return $countones(sel) == 1;
`else
      return (sel == sel) && (lo == lo);
`endif
   endfunction

   // One full request: present in cycle 0, scramble inputs while committed, check ack in cycle LATENCY.
   task automatic txn(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                      input logic [31:0] wdata);
      int          idx;
      bit          legal;
      logic [31:0] exp_rd;
      logic [31:0] word;
      idx    = int'((addr >> 2) % (32'd1 << ADDR_W));
      legal  = is_legal(sel, addr[1:0]);
      exp_rd = 32'h0;
      if (!we && legal) exp_rd = ref_mem[idx];
      if (we && legal) begin
         word = ref_mem[idx];
         for (int i = 0; i < 4; i++)
            if (sel[i]) word[8*i +: 8] = wdata[8*i +: 8];
         ref_mem[idx] = word;
      end

      @(negedge clk);
      req_ce = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
      #1;
      chk1("c0_ready", req_ready, 1'b1);
      chk1("c0_stall", stallreq, 1'b1);
      chk1("c0_ack", resp_ack, 1'b0);
      for (int c = 1; c <= LATENCY; c++) begin
         @(negedge clk);
         req_we = 1'($urandom); req_sel = 4'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
         #1;
         if (c < LATENCY) begin
            chk1("wait_ack", resp_ack, 1'b0);
            chk1("wait_stall", stallreq, 1'b1);
            chk1("wait_ready", req_ready, 1'b0);
         end else begin
            chk1("resp_ack", resp_ack, 1'b1);
            chk1("resp_stall", stallreq, 1'b0);
            chk1("resp_ready", req_ready, 1'b0);
            chk("resp_rdata", resp_rdata, exp_rd);
`ifdef DRAM_ALIGN_CHK_EN
            chk1("resp_err", resp_err, !legal);
`endif
         end
      end
      last_rdata = exp_rd;
      $display("txn we=%0d sel=%b addr=%08h wdata=%08h exp_rdata=%08h legal=%0d",
               we, sel, addr, wdata, exp_rd, legal);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         req_ce = 1'b0; req_we = 1'($urandom); req_sel = 4'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
         #1;
         chk1("idle_ready", req_ready, 1'b1);
         chk1("idle_ack", resp_ack, 1'b0);
         chk1("idle_stall", stallreq, 1'b0);
         chk("idle_rdata_hold", resp_rdata, last_rdata);
      end
   endtask

   initial begin
      // Reset state
      #2;
      chk1("rst_ready", req_ready, 1'b1);
      chk1("rst_ack", resp_ack, 1'b0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk1("rst_stall0", stallreq, 1'b0);
      req_ce = 1'b1;
      #1;
      chk1("rst_stall1", stallreq, 1'b1);
      req_ce = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle(1);

      // Known contents for the word pool
      for (int w = 0; w < 8; w++) txn(1'b1, 4'b1111, 32'(w * 4), 32'h0);
      idle(1);

      // Directed: full store/load, partial store, neighbour untouched, aliasing
      txn(1'b1, 4'b1111, 32'h0000_0010, 32'hDEAD_BEEF);
      txn(1'b0, 4'b0000, 32'h0000_0010, 32'h0);
      idle(2);
      txn(1'b1, 4'b0100, 32'h0000_0010, 32'h00AA_0000);
      txn(1'b0, 4'b1111, 32'h0000_0010, 32'h0);
      txn(1'b0, 4'b1111, 32'h0000_0014, 32'h0);
      txn(1'b1, 4'b0000, 32'h0000_0014, 32'hFFFF_FFFF);
      txn(1'b0, 4'b1111, 32'h0000_0014, 32'h0);
      txn(1'b1, 4'b1111, 32'h0000_1010, 32'h1234_5678);
      txn(1'b0, 4'b1111, 32'h0000_0010, 32'h0);
      idle(3);
      txn(1'b1, 4'b1111, 32'h0000_0012, 32'hCAFE_F00D);
      txn(1'b0, 4'b1111, 32'h0000_0010, 32'h0);
      txn(1'b1, 4'b0001, 32'h0000_0013, 32'h0000_0099);
      txn(1'b0, 4'b1111, 32'h0000_0010, 32'h0);

      // Async reset in WAIT of a load: ack discarded, outputs back to reset values
      @(negedge clk);
      req_ce = 1'b1; req_we = 1'b0; req_sel = 4'b1111; req_addr = 32'h0000_0010;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk1("arst_ready", req_ready, 1'b1);
      chk1("arst_ack", resp_ack, 1'b0);
      chk("arst_rdata", resp_rdata, 32'h0);
      chk1("arst_stall", stallreq, 1'b1);
      last_rdata = 32'h0;
      @(negedge clk);
      req_ce = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle(LATENCY + 2);
      txn(1'b0, 4'b1111, 32'h0000_0010, 32'h0);
      idle(1);

      // Randomized traffic over the pool, with random alias bits and idle gaps
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         txn(1'($urandom), 4'($urandom), a, $urandom);
         idle($urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
